// File: rtl/uart_loader_if.sv
// Byte-stream input and memory-write port bundle for the UART frame loader.
// The master side is the loader itself; the slave side is the UART/memory environment.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  i_Rx_DV;
    logic [7:0]            i_Rx_Byte;
    logic [ADDR_WIDTH-1:0] o_Mem_Addr;
    logic [7:0]            o_Mem_Data;
    logic                  o_Mem_WE;
    logic                  i_Mem_Ack;
    logic                  o_Busy;
    logic                  o_Done;
    logic                  o_Error;
    logic [1:0]            o_Err_Code;

    modport master (
        input  i_Rx_DV, i_Rx_Byte, i_Mem_Ack,
        output o_Mem_Addr, o_Mem_Data, o_Mem_WE, o_Busy, o_Done, o_Error, o_Err_Code
    );

    modport slave (
        output i_Rx_DV, i_Rx_Byte, i_Mem_Ack,
        input  o_Mem_Addr, o_Mem_Data, o_Mem_WE, o_Busy, o_Done, o_Error, o_Err_Code
    );
endinterface

// File: rtl/uart_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream and writes the
// payload to memory through a held write-request/acknowledge handshake.
module uart_loader #(
    parameter int         ADDR_WIDTH   = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input logic           i_Clock,
    input logic           i_Reset_n,
    uart_loader_if.master bus
);
    localparam int              GAP_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx;
    logic [7:0]            data, data_nx;
    logic [7:0]            addr_hi, addr_hi_nx;
    logic [7:0]            sum, sum_nx;
    logic [8:0]            count, count_nx;
    logic [GAP_W-1:0]      gap, gap_nx;
    logic                  we, we_nx;
    logic                  done, done_nx;
    logic                  error, error_nx;
    logic [1:0]            err_code, err_code_nx;

    logic                  rx;
    logic [7:0]            rx_byte;
    logic [7:0]            sum_b;
    logic [15:0]           full_addr;
    logic                  timed_out;

    assign rx        = bus.i_Rx_DV;
    assign rx_byte   = bus.i_Rx_Byte;
    assign sum_b     = sum + rx_byte;
    assign full_addr = {addr_hi, rx_byte};
    // Saturating gap counter; a timeout that matured during WRITE fires once the write is acked.
    assign timed_out = (gap >= GAP_LIMIT);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            data     <= '0;
            addr_hi  <= '0;
            sum      <= '0;
            count    <= '0;
            gap      <= '0;
            we       <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nx;
            addr     <= addr_nx;
            data     <= data_nx;
            addr_hi  <= addr_hi_nx;
            sum      <= sum_nx;
            count    <= count_nx;
            gap      <= gap_nx;
            we       <= we_nx;
            done     <= done_nx;
            error    <= error_nx;
            err_code <= err_code_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        data_nx     = data;
        addr_hi_nx  = addr_hi;
        sum_nx      = sum;
        count_nx    = count;
        we_nx       = we;
        done_nx     = 1'b0;
        error_nx    = 1'b0;
        err_code_nx = err_code;

        if (rx || state == S_IDLE) begin
            gap_nx = '0;
        end else if (gap < GAP_LIMIT) begin
            gap_nx = gap + 1'b1;
        end else begin
            gap_nx = gap;
        end

        case (state)
            S_IDLE: begin
                if (rx && rx_byte == SYNC_BYTE) begin
                    sum_nx   = '0;
                    state_nx = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (rx) begin
                    addr_hi_nx = rx_byte;
                    sum_nx     = sum_b;
                    state_nx   = S_ADDR_LO;
                end else if (timed_out) begin
                    error_nx    = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_ADDR_LO: begin
                if (rx) begin
                    addr_nx  = full_addr[ADDR_WIDTH-1:0];
                    sum_nx   = sum_b;
                    state_nx = S_LEN;
                end else if (timed_out) begin
                    error_nx    = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_LEN: begin
                if (rx) begin
                    count_nx = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    sum_nx   = sum_b;
                    state_nx = S_DATA;
                end else if (timed_out) begin
                    error_nx    = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx) begin
                    data_nx  = rx_byte;
                    we_nx    = 1'b1;
                    sum_nx   = sum_b;
                    state_nx = S_WRITE;
                end else if (timed_out) begin
                    error_nx    = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_WRITE: begin
                if (bus.i_Mem_Ack) begin
                    addr_nx  = addr + 1'b1;
                    count_nx = count - 9'd1;
                    if (rx && count == 9'd1) begin
                        // The byte arriving with the final ack is the checksum.
                        we_nx    = 1'b0;
                        state_nx = S_IDLE;
                        if (sum_b == 8'h00) begin
                            done_nx     = 1'b1;
                            err_code_nx = ERR_NONE;
                        end else begin
                            error_nx    = 1'b1;
                            err_code_nx = ERR_CHECKSUM;
                        end
                    end else if (rx) begin
                        data_nx = rx_byte;
                        sum_nx  = sum_b;
                        we_nx   = 1'b1;
                    end else begin
                        we_nx    = 1'b0;
                        state_nx = (count == 9'd1) ? S_CHK : S_DATA;
                    end
                end else if (rx) begin
                    we_nx       = 1'b0;
                    error_nx    = 1'b1;
                    err_code_nx = ERR_OVERRUN;
                    state_nx    = S_IDLE;
                end
            end
            S_CHK: begin
                if (rx) begin
                    state_nx = S_IDLE;
                    if (sum_b == 8'h00) begin
                        done_nx     = 1'b1;
                        err_code_nx = ERR_NONE;
                    end else begin
                        error_nx    = 1'b1;
                        err_code_nx = ERR_CHECKSUM;
                    end
                end else if (timed_out) begin
                    error_nx    = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            default: begin
                we_nx    = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.o_Mem_Addr = addr;
    assign bus.o_Mem_Data = data;
    assign bus.o_Mem_WE   = we;
    assign bus.o_Busy     = (state != S_IDLE);
    assign bus.o_Done     = done;
    assign bus.o_Error    = error;
    assign bus.o_Err_Code = err_code;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of short frames plus hand-written
// sequences for wrap, LEN=0, overrun, timeout, ack/byte collision and reset.
module tb_uart_loader;
    localparam int TMO = 40;

    logic clk;
    logic rst_n;
    logic auto_ack;
    logic man_ack;

    uart_loader_if #(.ADDR_WIDTH(16)) bus ();

    uart_loader #(
        .ADDR_WIDTH  (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock  (clk),
        .i_Reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.i_Mem_Ack = auto_ack ? bus.o_Mem_WE : man_ack;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        both_seen = 1'b0;
    logic [23:0] wlog[$];

    // Writes and status pulses are observed mid-cycle, when everything is stable.
    always @(negedge clk) begin
        if (bus.o_Mem_WE && bus.i_Mem_Ack) wlog.push_back({bus.o_Mem_Addr, bus.o_Mem_Data});
        if (bus.o_Done) done_cnt++;
        if (bus.o_Error) err_cnt++;
        if (bus.o_Done && bus.o_Error) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(posedge clk); #1;
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]       hi;
        logic [7:0]       lo;
        logic [7:0]       len;
        logic [1:0][7:0]  d;
        logic [7:0]       chk;
        int               nwr;
        logic [1:0][15:0] wa;
        int               ndone;
        int               nerr;
        logic [1:0]       code;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0, e0, n, bad;
        logic [7:0] s;

        vecs[0] = '{8'h12, 8'h34, 8'h02, {8'h55, 8'hAA}, 8'hB9, 2, {16'h1235, 16'h1234}, 1, 0, 2'd0};
        vecs[1] = '{8'h12, 8'h34, 8'h02, {8'h55, 8'hAA}, 8'h6C, 2, {16'h1235, 16'h1234}, 0, 1, 2'd1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h02, {8'h02, 8'h01}, 8'hFD, 2, {16'h0000, 16'hFFFF}, 1, 0, 2'd0};
        vecs[3] = '{8'h00, 8'h10, 8'h01, {8'h00, 8'h7E}, 8'h71, 1, {16'h0000, 16'h0010}, 1, 0, 2'd0};

        rst_n = 1'b0;
        auto_ack = 1'b1;
        man_ack = 1'b0;
        bus.i_Rx_DV = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        idle(3);
        check("rst_we", bus.o_Mem_WE, 0);
        check("rst_busy", bus.o_Busy, 0);
        check("rst_done", bus.o_Done, 0);
        check("rst_error", bus.o_Error, 0);
        check("rst_code", bus.o_Err_Code, 0);
        check("rst_addr", bus.o_Mem_Addr, 0);
        check("rst_data", bus.o_Mem_Data, 0);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            wlog.delete();
            d0 = done_cnt;
            e0 = err_cnt;
            send_byte(8'hA5);
            send_byte(vecs[v].hi);
            send_byte(vecs[v].lo);
            send_byte(vecs[v].len);
            for (int i = 0; i < int'(vecs[v].len); i++) send_byte(vecs[v].d[i]);
            send_byte(vecs[v].chk);
            idle(3);
            check($sformatf("v%0d_nwr", v), wlog.size(), vecs[v].nwr);
            for (int i = 0; i < vecs[v].nwr; i++) begin
                if (i < wlog.size()) begin
                    check($sformatf("v%0d_addr%0d", v, i), wlog[i][23:8], vecs[v].wa[i]);
                    check($sformatf("v%0d_data%0d", v, i), wlog[i][7:0], vecs[v].d[i]);
                end
            end
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].ndone);
            check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].nerr);
            check($sformatf("v%0d_code", v), bus.o_Err_Code, vecs[v].code);
            check($sformatf("v%0d_busy", v), bus.o_Busy, 0);
        end

        // LEN=0 carries 256 bytes
        wlog.delete();
        d0 = done_cnt;
        s = 8'h20;
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            s = s + 8'(i);
        end
        send_byte(8'(-s));
        idle(3);
        check("len0_nwr", wlog.size(), 256);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {16'h2000 + 16'(i), 8'(i)}) bad++;
        check("len0_log_bad", bad, 0);
        check("len0_done", done_cnt - d0, 1);

        // Overrun: second byte arrives while the first write is still pending
        auto_ack = 1'b0;
        wlog.delete();
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11);
        check("ovr_we_up", bus.o_Mem_WE, 1);
        idle(2);
        check("ovr_hold_addr", bus.o_Mem_Addr, 16'h3000);
        check("ovr_hold_data", bus.o_Mem_Data, 8'h11);
        check("ovr_hold_we", bus.o_Mem_WE, 1);
        send_byte(8'h22);
        check("ovr_error", bus.o_Error, 1);
        check("ovr_code", bus.o_Err_Code, 2);
        check("ovr_we_low", bus.o_Mem_WE, 0);
        check("ovr_busy", bus.o_Busy, 0);
        idle(2);
        check("ovr_err_cnt", err_cnt - e0, 1);
        check("ovr_nwr", wlog.size(), 0);

        // Timeout during header; leading non-sync bytes are ignored
        auto_ack = 1'b1;
        e0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("pre_busy", bus.o_Busy, 0);
        check("pre_err", err_cnt - e0, 0);
        send_byte(8'hA5);
        send_byte(8'h12);
        n = 0;
        for (int i = 1; i <= TMO + 10; i++) begin
            @(posedge clk); #1;
            if (bus.o_Error) begin
                n = i;
                break;
            end
        end
        check("tmo_cycles", n, TMO);
        check("tmo_code", bus.o_Err_Code, 3);
        check("tmo_busy", bus.o_Busy, 0);
        idle(2);
        check("tmo_err_cnt", err_cnt - e0, 1);

        // Timeout held off while a write is pending, raised right after the ack
        auto_ack = 1'b0;
        wlog.delete();
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h60); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h44);
        idle(TMO + 5);
        check("wtmo_no_err", err_cnt - e0, 0);
        check("wtmo_we_held", bus.o_Mem_WE, 1);
        check("wtmo_addr", bus.o_Mem_Addr, 16'h6000);
        man_ack = 1'b1;
        idle(1);
        man_ack = 1'b0;
        check("wtmo_we_drop", bus.o_Mem_WE, 0);
        idle(4);
        check("wtmo_err", err_cnt - e0, 1);
        check("wtmo_code", bus.o_Err_Code, 3);
        check("wtmo_nwr", wlog.size(), 1);

        // Ack and next byte in the same cycle
        wlog.delete();
        d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA);
        @(posedge clk); #1;
        man_ack = 1'b1;
        bus.i_Rx_DV = 1'b1;
        bus.i_Rx_Byte = 8'h55;
        @(posedge clk); #1;
        man_ack = 1'b0;
        bus.i_Rx_DV = 1'b0;
        check("coll_we", bus.o_Mem_WE, 1);
        check("coll_addr", bus.o_Mem_Addr, 16'h4001);
        check("coll_data", bus.o_Mem_Data, 8'h55);
        auto_ack = 1'b1;
        idle(2);
        send_byte(8'hBF);
        idle(3);
        check("coll_nwr", wlog.size(), 2);
        if (wlog.size() == 2) check("coll_w1", wlog[1], {16'h4001, 8'h55});
        check("coll_done", done_cnt - d0, 1);

        // Reset in the middle of a pending write
        auto_ack = 1'b0;
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h50); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h33);
        check("mrst_we_up", bus.o_Mem_WE, 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("mrst_we", bus.o_Mem_WE, 0);
        check("mrst_busy", bus.o_Busy, 0);
        check("mrst_addr", bus.o_Mem_Addr, 0);
        idle(2);
        check("mrst_no_err", err_cnt - e0, 0);
        auto_ack = 1'b1;
        wlog.delete();
        d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'hB9);
        idle(3);
        check("mrst_done", done_cnt - d0, 1);
        check("mrst_nwr", wlog.size(), 2);

        check("done_error_overlap", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
